// File: rtl/fp_adder_pkg.sv
// Shared FP adder definitions used by the exponent adjust stage.
//   - adjust command encodings (MODE_HOLD / MODE_INC / MODE_DEC, 2'b11 reserved)
//   - exponent width defaults for single and double precision
//   - exp_adj_res_t: one adjusted result (exponent, tag, overflow, underflow)
// exp_adj_res_t fields are sized for the widest supported configuration.
// Users zero-extend into them and slice back down to their own widths.
package fp_adder_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_INC  = 2'b01;
  localparam logic [1:0] MODE_DEC  = 2'b10;

  localparam int EXP_W_SINGLE = 8;
  localparam int EXP_W_DOUBLE = 11;

  // Upper bounds for EXP_W / TAG_W carried inside exp_adj_res_t.
  localparam int EXP_W_MAX = 16;
  localparam int TAG_W_MAX = 16;

  typedef struct packed {
    logic [EXP_W_MAX-1:0] exp;
    logic [TAG_W_MAX-1:0] tag;
    logic                 ovf;
    logic                 udf;
  } exp_adj_res_t;

endpackage

// File: rtl/exp_adjust_pipe_if.sv
// Handshake bundle for exp_adjust_pipe.
// Input side:
//   in_valid, in_ready, in_exp, in_shift, in_mode, in_tag
// Output side:
//   out_valid, out_ready, out_exp, out_tag, out_ovf, out_udf
// Modports:
//   master - the surrounding logic (drives inputs, consumes outputs)
//   slave  - the adjust stage itself
interface exp_adjust_pipe_if #(
  parameter int EXP_W   = 8,
  parameter int SHIFT_W = 5,
  parameter int TAG_W   = 4
);

  logic               in_valid;
  logic               in_ready;
  logic [EXP_W-1:0]   in_exp;
  logic [SHIFT_W-1:0] in_shift;
  logic [1:0]         in_mode;
  logic [TAG_W-1:0]   in_tag;

  logic               out_valid;
  logic               out_ready;
  logic [EXP_W-1:0]   out_exp;
  logic [TAG_W-1:0]   out_tag;
  logic               out_ovf;
  logic               out_udf;

  modport master (
    output in_valid, in_exp, in_shift, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_exp, out_tag, out_ovf, out_udf
  );

  modport slave (
    input  in_valid, in_exp, in_shift, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_exp, out_tag, out_ovf, out_udf
  );

endinterface

// File: rtl/exp_adjust_calc.sv
// Combinational exponent adjust arithmetic and flag logic.
// Ports:
//   in_exp   [EXP_W]   biased exponent
//   in_shift [SHIFT_W] normalisation shift (DEC only)
//   in_mode  [2]       HOLD / INC / DEC, reserved code behaves as HOLD
//   in_tag   [TAG_W]   opaque tag, passed through
//   res                adjusted result (exp_adj_res_t, zero-extended fields)
// Arithmetic runs in EXP_W+1 bits so the carry out of INC is visible.
module exp_adjust_calc
  import fp_adder_pkg::*;
#(
  parameter int EXP_W   = 8,
  parameter int SHIFT_W = 5,
  parameter int TAG_W   = 4
) (
  input  logic [EXP_W-1:0]   in_exp,
  input  logic [SHIFT_W-1:0] in_shift,
  input  logic [1:0]         in_mode,
  input  logic [TAG_W-1:0]   in_tag,
  output exp_adj_res_t       res
);

  localparam int W = EXP_W + 1;
  localparam logic [W-1:0] ALL_ONES_EXT = {1'b0, {EXP_W{1'b1}}};

  logic [W-1:0]     exp_ext;
  logic [W-1:0]     shift_ext;
  logic [W-1:0]     inc_sum;
  logic [EXP_W-1:0] dec_diff;
  logic [EXP_W-1:0] result;
  logic             ovf;
  logic             udf;

  assign exp_ext   = {1'b0, in_exp};
  assign shift_ext = W'(in_shift);
  assign inc_sum   = exp_ext + W'(1);
  assign dec_diff  = EXP_W'(exp_ext - shift_ext);

  always_comb begin
    result = in_exp;
    ovf    = 1'b0;
    udf    = 1'b0;
    case (in_mode)
      MODE_INC: begin
        // Reaching the all-ones code is already overflow (it is the
        // Inf/NaN exponent), so saturate there rather than only on carry.
        if (inc_sum >= ALL_ONES_EXT) begin
          result = {EXP_W{1'b1}};
          ovf    = 1'b1;
        end else begin
          result = inc_sum[EXP_W-1:0];
        end
      end
      MODE_DEC: begin
        // A result of zero or below is the denormal/zero exponent.
        if (exp_ext <= shift_ext) begin
          result = '0;
          udf    = 1'b1;
        end else begin
          result = dec_diff;
        end
      end
      default: result = in_exp;
    endcase
  end

  always_comb begin
    res     = '0;
    res.exp = EXP_W_MAX'(result);
    res.tag = TAG_W_MAX'(in_tag);
    res.ovf = ovf;
    res.udf = udf;
  end

endmodule

// File: rtl/exp_adjust_pipe.sv
// Exponent adjust stage for the FP adder normalisation path.
// Registered output with a one-entry skid buffer: in_ready comes straight
// from the skid-valid flop, so downstream stalls never reach upstream
// combinationally.
// Ports:
//   clk        clock
//   flush      synchronous active-high clear, overrides every handshake
//   bus        exp_adjust_pipe_if.slave (input and output handshakes)
//   ovf_count  [16] saturating count of consumed overflow results  (*)
//   udf_count  [16] saturating count of consumed underflow results (*)
// (*) present only when EXP_ADJ_STATS_EN is defined.
module exp_adjust_pipe
  import fp_adder_pkg::*;
#(
  parameter int EXP_W   = 8,
  parameter int SHIFT_W = 5,
  parameter int TAG_W   = 4
) (
  input  logic              clk,
  input  logic              flush,
  exp_adjust_pipe_if.slave  bus
`ifdef EXP_ADJ_STATS_EN
  ,
  output logic [15:0]       ovf_count,
  output logic [15:0]       udf_count
`endif
);

  exp_adj_res_t calc_res;
  exp_adj_res_t out_reg;
  exp_adj_res_t skid_reg;
  logic         out_valid_reg;
  logic         skid_valid_reg;
  logic         accept;
  logic         consume;
  logic         out_free;

  exp_adjust_calc #(
    .EXP_W   (EXP_W),
    .SHIFT_W (SHIFT_W),
    .TAG_W   (TAG_W)
  ) u_calc (
    .in_exp   (bus.in_exp),
    .in_shift (bus.in_shift),
    .in_mode  (bus.in_mode),
    .in_tag   (bus.in_tag),
    .res      (calc_res)
  );

  assign accept   = bus.in_valid && !skid_valid_reg && !flush;
  assign consume  = out_valid_reg && bus.out_ready;
  // Output register can take a new value this cycle.
  assign out_free = !out_valid_reg || consume;

  always_ff @(posedge clk) begin
    if (flush) begin
      out_valid_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
      out_reg        <= '0;
      skid_reg       <= '0;
    end else if (out_free) begin
      if (skid_valid_reg) begin
        // Older skid entry goes first; a same-cycle accept refills the skid.
        out_reg       <= skid_reg;
        out_valid_reg <= 1'b1;
        if (accept) begin
          skid_reg <= calc_res;
        end else begin
          skid_valid_reg <= 1'b0;
        end
      end else if (accept) begin
        out_reg       <= calc_res;
        out_valid_reg <= 1'b1;
      end else begin
        out_valid_reg <= 1'b0;
      end
    end else if (accept) begin
      // Output stalled: park the new result in the skid.
      skid_reg       <= calc_res;
      skid_valid_reg <= 1'b1;
    end
  end

  assign bus.in_ready  = !skid_valid_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_exp   = out_reg.exp[EXP_W-1:0];
  assign bus.out_tag   = out_reg.tag[TAG_W-1:0];
  assign bus.out_ovf   = out_reg.ovf;
  assign bus.out_udf   = out_reg.udf;

  // Upper bits of the package-wide struct are always zero here.
  logic unused_res_bits;
  assign unused_res_bits = ^{out_reg.exp, out_reg.tag};

`ifdef EXP_ADJ_STATS_EN
  logic [15:0] ovf_count_reg;
  logic [15:0] udf_count_reg;

  always_ff @(posedge clk) begin
    if (flush) begin
      ovf_count_reg <= '0;
      udf_count_reg <= '0;
    end else if (consume) begin
      if (out_reg.ovf && ovf_count_reg != 16'hFFFF) begin
        ovf_count_reg <= ovf_count_reg + 16'd1;
      end
      if (out_reg.udf && udf_count_reg != 16'hFFFF) begin
        udf_count_reg <= udf_count_reg + 16'd1;
      end
    end
  end

  assign ovf_count = ovf_count_reg;
  assign udf_count = udf_count_reg;
`endif

endmodule
